timebase_gen: RTL and testbench
===============================

Name: timebase_gen

Overview:
Parametrised successor to the fixed us/ms pulse pair in the clock/reset top. Provides a reset synchroniser with hold-off stretch, a cascaded us/ms/s pulse chain derived from clk_sys, a 32-bit uptime seconds counter, and N_CH independently programmable periodic tick channels counted in ms. Sits in clk_rst_top after the PLL. Replaces pluse_us_gen/pluse_ms_gen; all consumers in the clk_sys domain use its single-cycle strobes.

Parameters:
CLK_MHZ, 100, clk_sys cycles per us (>=2)
US_PER_MS, 1000, us pulses per ms pulse (override small for sim)
MS_PER_S, 1000, ms pulses per s pulse (override small for sim)
N_CH, 4, number of programmable tick channels (1..16)
PW, 16, width of each channel period field (ms units)
RST_HOLD_US, 10, us that rst_sync_n stays low after the synchroniser releases (0 = no stretch)

Ports:
clk_sys  in  1  system clock
rst_n  in  1  reset; asynchronous, active-low
en  in  1  timebase run enable; 0 freezes all counters
ch_en  in  N_CH  per-channel enable
ch_period  in  N_CH*PW  channel i period in ms at bits [i*PW +: PW]
pluse_us  out  1  1-cycle strobe every CLK_MHZ cycles
pluse_ms  out  1  1-cycle strobe every US_PER_MS us
pluse_s  out  1  1-cycle strobe every MS_PER_S ms
pluse_ch  out  N_CH  1-cycle strobe per channel every ch_period ms
sec_cnt  out  32  seconds since reset, wraps
rst_sync_n  out  1  synchronised, stretched reset for downstream logic

Behaviour:
- Reset (rst_n=0, async): all counters 0; pluse_* 0; sec_cnt 0; rst_sync_n 0 immediately.
- rst_sync_n: 2-flop synchroniser (async assert, sync release), then held low for RST_HOLD_US further pluse_us strobes; rises on the cycle after the RST_HOLD_US-th strobe. It uses its own always-running us count, independent of en.
- us stage: cnt_us 0..CLK_MHZ-1, increments while en=1. pluse_us=1 on the cycle cnt_us==CLK_MHZ-1 with en=1; cnt_us wraps to 0. First pluse_us occurs CLK_MHZ cycles after reset release with en held high.
- ms stage: cnt_ms counts pluse_us 0..US_PER_MS-1. pluse_ms is combinationally pluse_us && cnt_ms==US_PER_MS-1, registered to the same cycle as that pluse_us, with zero extra latency. s stage is identical, driven by pluse_ms/MS_PER_S.
- Strobes are co-incident: each pluse_s cycle also carries pluse_ms and pluse_us.
- en=0: all counters hold and all strobes are 0. Resuming continues from the held counts with no restart.
- sec_cnt: +1 on the cycle after pluse_s; wraps 0xFFFFFFFF->0.
- Channel i: cnt_ch[i] (PW bits).
  - ch_en[i] low, or period==0: counter forced to 0 and no pulse.
  - On a ch_en[i] rising edge the counter starts at 0.
  - On pluse_ms with cnt_ch >= period-1: pluse_ch[i]=1 in the same cycle and cnt_ch goes to 0. Otherwise, on pluse_ms, cnt_ch increments.
  - period==1 pulses on every pluse_ms.
  - Period reduced below the current count: fires on the next pluse_ms (>= compare), never waits for wrap.
- Width rule: counter widths are $clog2 of the modulus. No counter exceeds modulus-1.
- Mid-operation reset: everything returns to reset values asynchronously; rst_sync_n recovers per the rule above.

Decomposition:
- Package timebase_pkg: default constants (US_PER_MS_DEF=1000, MS_PER_S_DEF=1000), counter-width function cw(n)=max(1,$clog2(n)).
- Sub-module pluse_div, parameter DIV:
  - Inputs clk_sys, rst_n, en, tick_in; outputs tick_out, plus cnt for debug.
  - Modulo-DIV counter of tick_in with same-cycle carry out.
  - Instantiated three times: us stage with tick_in=1'b1, then ms, then s.
- Channel logic is a generate loop in timebase_gen.

Test Plan:
- CLK_MHZ=4, US_PER_MS=5, MS_PER_S=3, en=1 after reset -> pluse_us at cycles 3,7,11,…; first pluse_ms at cycle 19; first pluse_s at cycle 59, co-incident with pluse_ms and pluse_us; sec_cnt=1 at cycle 60.
- Same config, en dropped for 10 cycles at cycle 9 -> no strobes during the gap; next pluse_us at cycle 21 (11+10); all later strobes shifted by 10.
- RST_HOLD_US=3, rst_n released at cycle 0 -> rst_sync_n stays 0 through the 3rd us strobe of the internal hold count, then goes 1 on the next cycle. Asserting rst_n for 1 ns mid-run -> rst_sync_n drops immediately and all counters read 0.
- Channel 0 period=3, channel 1 period=1, channel 2 period=0, all enabled -> ch0 pulses on every 3rd pluse_ms; ch1 pulses on every pluse_ms; ch2 never pulses.
- Channel 0 period=10 at count 7, reprogrammed to 4 -> pluse_ch[0] on the next pluse_ms, then every 4th. Toggling ch_en[0] low then high restarts the count at 0.
- sec_cnt preloaded via force to 0xFFFFFFFF -> wraps to 0 after the next pluse_s.

Source files
------------

// File: rtl/timebase_pkg.sv
`timescale 1ns/100ps
// Shared constants and helpers for the timebase generator.
package timebase_pkg;

  localparam int US_PER_MS_DEF = 1000;
  localparam int MS_PER_S_DEF  = 1000;

  // Width of a counter that runs 0..n-1; never narrower than one bit.
  function automatic int cw(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/timebase_gen_pluse_div.sv
`timescale 1ns/100ps
// Modulo-DIV counter of tick_in; tick_out is the same-cycle carry, so cascaded
// stages produce co-incident strobes.
module pluse_div
  import timebase_pkg::*;
#(
  parameter int DIV = 4
) (
  input  logic                 clk_sys,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic                 tick_in,
  output logic                 tick_out,
  output logic [cw(DIV)-1:0]   cnt
);

  localparam int W = cw(DIV);
  localparam logic [W-1:0] LAST = W'(DIV - 1);

  logic [W-1:0] cnt_reg;
  logic         at_last;

  assign at_last  = (cnt_reg == LAST);
  assign tick_out = en && tick_in && at_last;
  assign cnt      = cnt_reg;

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg <= '0;
    end else if (en && tick_in) begin
      cnt_reg <= at_last ? '0 : cnt_reg + 1'b1;
    end
  end

endmodule

// File: rtl/timebase_gen.sv
`timescale 1ns/100ps
// Cascaded us/ms/s strobes, uptime seconds, programmable ms tick channels and
// a synchronised, stretched downstream reset.
module timebase_gen
  import timebase_pkg::*;
#(
  parameter int CLK_MHZ     = 100,
  parameter int US_PER_MS   = US_PER_MS_DEF,
  parameter int MS_PER_S    = MS_PER_S_DEF,
  parameter int N_CH        = 4,
  parameter int PW          = 16,
  parameter int RST_HOLD_US = 10
) (
  input  logic               clk_sys,
  input  logic               rst_n,
  input  logic               en,
  input  logic [N_CH-1:0]    ch_en,
  input  logic [N_CH*PW-1:0] ch_period,
  output logic               pluse_us,
  output logic               pluse_ms,
  output logic               pluse_s,
  output logic [N_CH-1:0]    pluse_ch,
  output logic [31:0]        sec_cnt,
  output logic               rst_sync_n
);

  logic [cw(CLK_MHZ)-1:0]   cnt_us;
  logic [cw(US_PER_MS)-1:0] cnt_ms;
  logic [cw(MS_PER_S)-1:0]  cnt_s;
  logic [31:0]              sec_cnt_reg;
  logic [1:0]               sync_reg;

  pluse_div #(.DIV(CLK_MHZ)) u_us (
    .clk_sys(clk_sys), .rst_n(rst_n), .en(en), .tick_in(1'b1),
    .tick_out(pluse_us), .cnt(cnt_us)
  );

  pluse_div #(.DIV(US_PER_MS)) u_ms (
    .clk_sys(clk_sys), .rst_n(rst_n), .en(en), .tick_in(pluse_us),
    .tick_out(pluse_ms), .cnt(cnt_ms)
  );

  pluse_div #(.DIV(MS_PER_S)) u_s (
    .clk_sys(clk_sys), .rst_n(rst_n), .en(en), .tick_in(pluse_ms),
    .tick_out(pluse_s), .cnt(cnt_s)
  );

  // Stage counts stay as named nets for probing only.
  logic unused_dbg;
  assign unused_dbg = ^{cnt_us, cnt_ms, cnt_s};

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      sec_cnt_reg <= '0;
    end else if (pluse_s) begin
      sec_cnt_reg <= sec_cnt_reg + 32'd1;
    end
  end

  assign sec_cnt = sec_cnt_reg;

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      sync_reg <= 2'b00;
    end else begin
      sync_reg <= {sync_reg[0], 1'b1};
    end
  end

  generate
    if (RST_HOLD_US == 0) begin : g_no_hold
      assign rst_sync_n = sync_reg[1];
    end else begin : g_hold
      localparam int HW = cw(RST_HOLD_US);
      logic [cw(CLK_MHZ)-1:0] hold_fr_cnt;
      logic                   hold_fr_tick;
      logic [HW-1:0]          hold_cnt_reg;
      logic                   hold_done_reg;
      logic                   unused_hold;

      // Free-running us count so the stretch is unaffected by en.
      pluse_div #(.DIV(CLK_MHZ)) u_hold_us (
        .clk_sys(clk_sys), .rst_n(rst_n), .en(1'b1), .tick_in(1'b1),
        .tick_out(hold_fr_tick), .cnt(hold_fr_cnt)
      );
      assign unused_hold = ^hold_fr_cnt;

      always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
          hold_cnt_reg  <= '0;
          hold_done_reg <= 1'b0;
        end else if (sync_reg[1] && !hold_done_reg && hold_fr_tick) begin
          if (hold_cnt_reg == HW'(RST_HOLD_US - 1)) begin
            hold_done_reg <= 1'b1;
          end else begin
            hold_cnt_reg <= hold_cnt_reg + 1'b1;
          end
        end
      end

      assign rst_sync_n = hold_done_reg;
    end
  endgenerate

  genvar gi;
  generate
    for (gi = 0; gi < N_CH; gi++) begin : g_ch
      logic [PW-1:0] period;
      logic [PW-1:0] cnt_ch_reg;
      logic          active;
      logic          hit;

      assign period = ch_period[gi*PW +: PW];
      assign active = ch_en[gi] && (period != '0);
      // >= compare lets a shortened period fire at once instead of wrapping.
      assign hit    = pluse_ms && (cnt_ch_reg >= period - 1'b1);
      assign pluse_ch[gi] = active && hit;

      always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
          cnt_ch_reg <= '0;
        end else if (!active) begin
          cnt_ch_reg <= '0;
        end else if (pluse_ms) begin
          cnt_ch_reg <= hit ? '0 : cnt_ch_reg + 1'b1;
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_timebase_gen.sv
`timescale 1ns/100ps
// Directed bench for timebase_gen with small divider ratios (4/5/3) and 3 us hold.
module tb_timebase_gen;

  localparam int N_CH = 4;
  localparam int PW   = 8;

  logic               clk_sys = 1'b0;
  logic               rst_n;
  logic               en;
  logic [N_CH-1:0]    ch_en;
  logic [N_CH*PW-1:0] ch_period;
  logic               pluse_us, pluse_ms, pluse_s;
  logic [N_CH-1:0]    pluse_ch;
  logic [31:0]        sec_cnt;
  logic               rst_sync_n;

  int checks = 0;
  int errors = 0;

  timebase_gen #(
    .CLK_MHZ(4), .US_PER_MS(5), .MS_PER_S(3), .N_CH(N_CH), .PW(PW), .RST_HOLD_US(3)
  ) dut (
    .clk_sys(clk_sys), .rst_n(rst_n), .en(en), .ch_en(ch_en), .ch_period(ch_period),
    .pluse_us(pluse_us), .pluse_ms(pluse_ms), .pluse_s(pluse_s), .pluse_ch(pluse_ch),
    .sec_cnt(sec_cnt), .rst_sync_n(rst_sync_n)
  );

  always #5 clk_sys = ~clk_sys;

  typedef struct {
    int          scen;
    int          cyc;
    bit          us;
    bit          ms;
    bit          s;
    logic [31:0] sec;
    logic [3:0]  ch;
    bit          rs;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input int scen, input int cyc, input bit us, input bit ms,
                     input bit s, input int sec, input logic [3:0] ch, input bit rs);
    vec_t v;
    v.scen = scen; v.cyc = cyc; v.us = us; v.ms = ms; v.s = s;
    v.sec = sec; v.ch = ch; v.rs = rs;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end else begin
      $display("ok   %s = %h", name, act);
    end
  endtask

  // Cycle c is sampled after the c-th rising edge following reset release.
  task automatic run_scen(input int s, input int last);
    for (int c = 0; c <= last; c++) begin
      if (c > 0) begin
        @(negedge clk_sys);
        en = !(s == 1 && c >= 9 && c <= 18);
        #1;
      end
      foreach (vecs[k]) begin
        if (vecs[k].scen == s && vecs[k].cyc == c) begin
          chk($sformatf("s%0d_c%0d_us", s, c), pluse_us, vecs[k].us);
          chk($sformatf("s%0d_c%0d_ms", s, c), pluse_ms, vecs[k].ms);
          chk($sformatf("s%0d_c%0d_s", s, c), pluse_s, vecs[k].s);
          chk($sformatf("s%0d_c%0d_sec", s, c), sec_cnt, vecs[k].sec);
          chk($sformatf("s%0d_c%0d_ch", s, c), pluse_ch, vecs[k].ch);
          chk($sformatf("s%0d_c%0d_rs", s, c), rst_sync_n, vecs[k].rs);
        end
      end
    end
  endtask

  task automatic wait_ms(output bit fired);
    bit found = 0;
    fired = 0;
    for (int k = 0; k < 100 && !found; k++) begin
      @(negedge clk_sys);
      #1;
      if (pluse_ms) begin
        found = 1;
        fired = pluse_ch[0];
      end
    end
    if (!found) begin
      checks++;
      errors++;
      $display("FAIL wait_ms timeout actual=no_pulse expected=pluse_ms");
    end
  endtask

  task automatic wait_s();
    bit found = 0;
    for (int k = 0; k < 200 && !found; k++) begin
      @(negedge clk_sys);
      #1;
      if (pluse_s) found = 1;
    end
    if (!found) begin
      checks++;
      errors++;
      $display("FAIL wait_s timeout actual=no_pulse expected=pluse_s");
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit f;
    int fires;

    rst_n     = 1'b0;
    en        = 1'b1;
    ch_en     = 4'b0111;
    ch_period = {8'd2, 8'd0, 8'd1, 8'd3};

    // scenario 0: free run from reset
    add(0,   0, 0, 0, 0, 0, 4'b0000, 0);
    add(0,   3, 1, 0, 0, 0, 4'b0000, 0);
    add(0,   4, 0, 0, 0, 0, 4'b0000, 0);
    add(0,  11, 1, 0, 0, 0, 4'b0000, 0);
    add(0,  12, 0, 0, 0, 0, 4'b0000, 1);
    add(0,  19, 1, 1, 0, 0, 4'b0010, 1);
    add(0,  20, 0, 0, 0, 0, 4'b0000, 1);
    add(0,  39, 1, 1, 0, 0, 4'b0010, 1);
    add(0,  59, 1, 1, 1, 0, 4'b0011, 1);
    add(0,  60, 0, 0, 0, 1, 4'b0000, 1);
    add(0,  79, 1, 1, 0, 1, 4'b0010, 1);
    add(0, 119, 1, 1, 1, 1, 4'b0011, 1);
    add(0, 120, 0, 0, 0, 2, 4'b0000, 1);
    // scenario 1: en low for cycles 9..18, everything shifts by 10
    add(1,   3, 1, 0, 0, 0, 4'b0000, 0);
    add(1,   7, 1, 0, 0, 0, 4'b0000, 0);
    add(1,   9, 0, 0, 0, 0, 4'b0000, 0);
    add(1,  11, 0, 0, 0, 0, 4'b0000, 0);
    add(1,  12, 0, 0, 0, 0, 4'b0000, 1);
    add(1,  15, 0, 0, 0, 0, 4'b0000, 1);
    add(1,  19, 0, 0, 0, 0, 4'b0000, 1);
    add(1,  21, 1, 0, 0, 0, 4'b0000, 1);
    add(1,  29, 1, 1, 0, 0, 4'b0010, 1);
    add(1,  49, 1, 1, 0, 0, 4'b0010, 1);
    add(1,  69, 1, 1, 1, 0, 4'b0011, 1);
    add(1,  70, 0, 0, 0, 1, 4'b0000, 1);

    repeat (2) @(negedge clk_sys);
    @(negedge clk_sys);
    rst_n = 1'b1;
    #1;
    run_scen(0, 120);

    // short asynchronous reset mid-run
    #1;
    rst_n = 1'b0;
    #0.5;
    chk("midrst_rs", rst_sync_n, 0);
    chk("midrst_sec", sec_cnt, 0);
    chk("midrst_us", pluse_us, 0);
    chk("midrst_cnt_us", 32'(dut.cnt_us), 0);
    chk("midrst_ch", pluse_ch, 0);
    #0.5;
    rst_n = 1'b1;
    run_scen(1, 70);

    // channel 0 reprogramming and enable restart
    ch_period[7:0] = 8'd10;
    @(negedge clk_sys);
    ch_en[0] = 1'b0;
    @(negedge clk_sys);
    ch_en[0] = 1'b1;
    fires = 0;
    repeat (7) begin
      wait_ms(f);
      fires += int'(f);
    end
    chk("ch0_p10_no_fire_7ms", fires, 0);
    @(negedge clk_sys);
    ch_period[7:0] = 8'd4;
    wait_ms(f);
    chk("ch0_reprog_fire_next", f, 1);
    for (int i = 1; i <= 4; i++) begin
      wait_ms(f);
      chk($sformatf("ch0_p4_ms%0d", i), f, (i == 4));
    end
    repeat (2) wait_ms(f);
    @(negedge clk_sys);
    ch_en[0] = 1'b0;
    @(negedge clk_sys);
    ch_en[0] = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      wait_ms(f);
      chk($sformatf("ch0_restart_ms%0d", i), f, (i == 4));
    end

    // seconds counter wrap
    wait_s();
    chk("s_coincident_ms_us", {pluse_ms, pluse_us}, 2'b11);
    @(negedge clk_sys);
    force dut.sec_cnt_reg = 32'hFFFF_FFFF;
    #1;
    release dut.sec_cnt_reg;
    #1;
    chk("sec_preload", sec_cnt, 32'hFFFF_FFFF);
    wait_s();
    chk("sec_before_wrap", sec_cnt, 32'hFFFF_FFFF);
    @(negedge clk_sys);
    #1;
    chk("sec_wrap", sec_cnt, 32'h0000_0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
